lif_tdm_array: RTL and testbench

Time-multiplexed array of N leaky integrate-and-fire neurons sharing one LIF update datapath. Per-neuron membrane state and refractory counters live in register arrays, and one neuron is updated per enabled clock, so a full sweep takes N cycles. It is the parametrised successor of the fixed four-instance LIF arrangement. It adds configurable neuron count, width, leak and threshold, a refractory period, and a runtime per-neuron chaining mask. The block sits between the input switches/decoder and the spike/state output muxing at the top level.

---
 rtl/lif_pkg.sv | 27 ++
 rtl/lif_core.sv | 47 ++++
 rtl/lif_tdm_array.sv | 146 ++++++++++++++
 tb/tb_lif_tdm_array.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: shared constants and helpers for the time-multiplexed LIF array.
//   DEF_* : default parameter values for lif_tdm_array / lif_core
//   SAT_W : working width of the saturating adder helper
//   sat_add(a, b, w) : a + b clamped to 2^w-1 (w < SAT_W)
package lif_pkg;

   localparam int DEF_N_NEURONS  = 4;
   localparam int DEF_WIDTH      = 8;
   localparam int DEF_THRESHOLD  = 200;
   localparam int DEF_LEAK_SHIFT = 1;
   localparam int DEF_REFRAC     = 2;
   localparam int SAT_W          = 32;

   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input int unsigned      w);
      logic [SAT_W:0] sum;
      logic [SAT_W:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
      if (sum > lim) begin
         return lim[SAT_W-1:0];
      end
      return sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/lif_core.sv
// lif_core: combinational leaky integrate-and-fire update for one neuron.
//   cur         : selected input current
//   state       : current membrane state
//   refrac      : remaining refractory sweeps
//   next_state  : membrane state after this update
//   next_refrac : refractory count after this update
//   spike       : neuron fired on this update
module lif_core
   import lif_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int THRESHOLD  = DEF_THRESHOLD,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
   parameter int REFRAC     = DEF_REFRAC,
   parameter int RW         = 2
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] state,
   input  logic [RW-1:0]    refrac,
   output logic [WIDTH-1:0] next_state,
   output logic [RW-1:0]    next_refrac,
   output logic             spike
);

   logic [WIDTH-1:0] leaked;
   logic [SAT_W-1:0] sum;

   always_comb begin
      leaked      = state >> LEAK_SHIFT;
      sum         = sat_add(SAT_W'(cur), SAT_W'(leaked), WIDTH);
      next_state  = leaked;
      next_refrac = refrac;
      spike       = 1'b0;
      if (refrac != '0) begin
         // refractory: leak only, input ignored
         next_refrac = refrac - RW'(1);
      end else if (sum >= SAT_W'(THRESHOLD)) begin
         next_state  = '0;
         next_refrac = RW'(REFRAC);
         spike       = 1'b1;
      end else begin
         // sum is already clamped to 2^WIDTH-1, so the upper bits are zero
         next_state = sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/lif_tdm_array.sv
// lif_tdm_array: N leaky integrate-and-fire neurons sharing one update
// datapath; one neuron is updated per enabled clock (sweep = N cycles).
//   clk, rst     : clock, asynchronous active-high reset
//   en           : advance the sweep; all registers hold when low
//   ext_current  : per-neuron external current, slice [i*WIDTH +: WIDTH]
//   chain_mask   : bit i (i>=1) selects neuron i-1's previous-sweep state as input
//   spikes       : spike vector of the last completed sweep
//   spike_valid  : one-cycle pulse when spikes updates
//   state_out    : live membrane states, slice [i*WIDTH +: WIDTH]
module lif_tdm_array
   import lif_pkg::*;
#(
   parameter int N_NEURONS  = DEF_N_NEURONS,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int THRESHOLD  = DEF_THRESHOLD,
   parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
   parameter int REFRAC     = DEF_REFRAC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [N_NEURONS*WIDTH-1:0] ext_current,
   input  logic [N_NEURONS-1:0]       chain_mask,
   output logic [N_NEURONS-1:0]       spikes,
   output logic                       spike_valid,
   output logic [N_NEURONS*WIDTH-1:0] state_out
);

   localparam int IW = $clog2(N_NEURONS);
   localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] state_q     [N_NEURONS];
   logic [WIDTH-1:0] state_d     [N_NEURONS];
   logic [RW-1:0]    refrac_q    [N_NEURONS];
   logic [RW-1:0]    refrac_d    [N_NEURONS];
   logic [WIDTH-1:0] ext_snap_q  [N_NEURONS];
   logic [WIDTH-1:0] ext_snap_d  [N_NEURONS];
   logic [WIDTH-1:0] prev_snap_q [N_NEURONS];
   logic [WIDTH-1:0] prev_snap_d [N_NEURONS];
   logic [N_NEURONS-1:0] mask_snap_q, mask_snap_d;
   logic [N_NEURONS-1:0] spk_acc_q, spk_acc_d;
   logic [N_NEURONS-1:0] spikes_q, spikes_d;
   logic                 spike_valid_q, spike_valid_d;

   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] core_state;
   logic [RW-1:0]    core_refrac;
   logic             core_spike;

   // Neuron 0 is processed in the same cycle the snapshot is taken, so it
   // reads the live input; it never chains.
   always_comb begin
      if (idx_q == '0) begin
         cur = ext_current[WIDTH-1:0];
      end else if (mask_snap_q[idx_q]) begin
         cur = prev_snap_q[idx_q - IW'(1)];
      end else begin
         cur = ext_snap_q[idx_q];
      end
   end

   lif_core #(
      .WIDTH      (WIDTH),
      .THRESHOLD  (THRESHOLD),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC),
      .RW         (RW)
   ) u_core (
      .cur         (cur),
      .state       (state_q[idx_q]),
      .refrac      (refrac_q[idx_q]),
      .next_state  (core_state),
      .next_refrac (core_refrac),
      .spike       (core_spike)
   );

   always_comb begin
      idx_d         = idx_q;
      state_d       = state_q;
      refrac_d      = refrac_q;
      ext_snap_d    = ext_snap_q;
      prev_snap_d   = prev_snap_q;
      mask_snap_d   = mask_snap_q;
      spk_acc_d     = spk_acc_q;
      spikes_d      = spikes_q;
      spike_valid_d = 1'b0;
      if (en) begin
         state_d[idx_q]   = core_state;
         refrac_d[idx_q]  = core_refrac;
         spk_acc_d[idx_q] = core_spike;
         if (idx_q == '0) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
               ext_snap_d[i] = ext_current[i*WIDTH +: WIDTH];
            end
            mask_snap_d = chain_mask;
            prev_snap_d = state_q;
         end
         if (idx_q == LAST) begin
            spikes_d      = spk_acc_d;
            spike_valid_d = 1'b1;
            idx_d         = '0;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         for (int unsigned i = 0; i < N_NEURONS; i++) begin
            state_q[i]     <= '0;
            refrac_q[i]    <= '0;
            ext_snap_q[i]  <= '0;
            prev_snap_q[i] <= '0;
         end
         mask_snap_q   <= '0;
         spk_acc_q     <= '0;
         spikes_q      <= '0;
         spike_valid_q <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         state_q       <= state_d;
         refrac_q      <= refrac_d;
         ext_snap_q    <= ext_snap_d;
         prev_snap_q   <= prev_snap_d;
         mask_snap_q   <= mask_snap_d;
         spk_acc_q     <= spk_acc_d;
         spikes_q      <= spikes_d;
         spike_valid_q <= spike_valid_d;
      end
   end

   always_comb begin
      state_out = '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
         state_out[i*WIDTH +: WIDTH] = state_q[i];
      end
   end

   assign spikes      = spikes_q;
   assign spike_valid = spike_valid_q;

endmodule

// File: tb/tb_lif_tdm_array.sv
// tb_lif_tdm_array: directed bench for lif_tdm_array. Two instances share
// stimulus: default parameters and a THRESHOLD=255 variant. A sweep-level
// arithmetic model is compared against both on every falling edge, and
// hand-computed literals pin the model in each scenario.
module tb_lif_tdm_array;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [31:0] ext = '0;
   logic [3:0]  mask = '0;

   logic [3:0]  spikes1, spikes2;
   logic        sv1, sv2;
   logic [31:0] so1, so2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lif_tdm_array #(.N_NEURONS(4), .WIDTH(8), .THRESHOLD(200), .LEAK_SHIFT(1), .REFRAC(2)) dut1 (
      .clk(clk), .rst(rst), .en(en), .ext_current(ext), .chain_mask(mask),
      .spikes(spikes1), .spike_valid(sv1), .state_out(so1));

   lif_tdm_array #(.N_NEURONS(4), .WIDTH(8), .THRESHOLD(255), .LEAK_SHIFT(1), .REFRAC(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .ext_current(ext), .chain_mask(mask),
      .spikes(spikes2), .spike_valid(sv2), .state_out(so2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int th[2] = '{200, 255};
   int m_state[2][4];
   int m_ref[2][4];
   int m_ext[2][4];
   int m_prev[2][4];
   int m_mask[2][4];
   int m_acc[2][4];
   int m_idx[2];
   int m_spikes[2];
   int m_sv[2];

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 4; k++) begin
            m_state[d][k] = 0; m_ref[d][k] = 0; m_ext[d][k] = 0;
            m_prev[d][k] = 0;  m_mask[d][k] = 0; m_acc[d][k] = 0;
         end
         m_idx[d] = 0; m_spikes[d] = 0; m_sv[d] = 0;
      end
   endtask

   task automatic model_step(input int d);
      int k, cur, leak, sum, sp;
      k = m_idx[d];
      if (k == 0) begin
         for (int j = 0; j < 4; j++) begin
            m_ext[d][j]  = int'(ext[j*8 +: 8]);
            m_mask[d][j] = int'(mask[j]);
            m_prev[d][j] = m_state[d][j];
         end
      end
      if (k >= 1 && m_mask[d][k] == 1) cur = m_prev[d][k-1];
      else cur = m_ext[d][k];
      leak = m_state[d][k] / 2;
      sp = 0;
      if (m_ref[d][k] > 0) begin
         m_state[d][k] = leak;
         m_ref[d][k]   = m_ref[d][k] - 1;
      end else begin
         sum = cur + leak;
         if (sum > 255) sum = 255;
         if (sum >= th[d]) begin
            m_state[d][k] = 0;
            m_ref[d][k]   = 2;
            sp = 1;
         end else begin
            m_state[d][k] = sum;
         end
      end
      m_acc[d][k] = sp;
      if (k == 3) begin
         m_spikes[d] = m_acc[d][0] + 2*m_acc[d][1] + 4*m_acc[d][2] + 8*m_acc[d][3];
         m_sv[d] = 1;
         m_idx[d] = 0;
      end else begin
         m_idx[d] = k + 1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_clear();
      end else begin
         for (int d = 0; d < 2; d++) begin
            m_sv[d] = 0;
            if (en) model_step(d);
         end
      end
   end

   function automatic logic [31:0] model_so(input int d);
      logic [31:0] v;
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(m_state[d][k]);
      return v;
   endfunction

   always @(negedge clk) begin
      check("cmp_spikes1", 32'(spikes1), 32'(m_spikes[0]));
      check("cmp_sv1",     32'(sv1),     32'(m_sv[0]));
      check("cmp_state1",  so1,          model_so(0));
      check("cmp_spikes2", 32'(spikes2), 32'(m_spikes[1]));
      check("cmp_sv2",     32'(sv2),     32'(m_sv[1]));
      check("cmp_state2",  so2,          model_so(1));
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   int exp_s0[8] = '{120, 180, 0, 0, 0, 120, 180, 0};
   int exp_sp[8] = '{0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      // reset and idle with en low
      cyc(2);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check("idle_sv", 32'(sv1), 32'd0);
         check("idle_spikes", 32'(spikes1), 32'd0);
         check("idle_state", so1, 32'd0);
      end

      // single neuron, 8 sweeps
      ext = 32'h0000_0078;
      mask = 4'b0000;
      en = 1'b1;
      for (int s = 0; s < 8; s++) begin
         cyc(3);
         check("single_sv_low", 32'(sv1), 32'd0);
         cyc(1);
         check("single_state0", 32'(so1[7:0]), 32'(exp_s0[s]));
         check("single_spikes", 32'(spikes1), 32'(exp_sp[s]));
         check("single_sv", 32'(sv1), 32'd1);
      end

      // chain neuron 0 -> neuron 1
      rst_pulse();
      mask = 4'b0010;
      ext = 32'h0000_0078;
      cyc(4);
      check("chain_s1_n1", 32'(so1[15:8]), 32'd0);
      cyc(4);
      check("chain_s2_n1", 32'(so1[15:8]), 32'd120);
      check("chain_s2_spk", 32'(spikes1), 32'd0);
      cyc(4);
      check("chain_s3_spk", 32'(spikes1), 32'b0011);
      check("chain_s3_n1", 32'(so1[15:8]), 32'd0);

      // saturation on the THRESHOLD=255 instance
      rst_pulse();
      mask = 4'b0000;
      ext = 32'h0000_00C8;
      cyc(4);
      check("sat_s1_state", 32'(so2[7:0]), 32'd200);
      check("sat_s1_spk", 32'(spikes2), 32'd0);
      cyc(4);
      check("sat_s2_spk", 32'(spikes2), 32'd1);
      check("sat_s2_state", 32'(so2[7:0]), 32'd0);

      // pause at idx=2 while ext[3] changes
      rst_pulse();
      ext = 32'h6400_0078;
      cyc(2);
      en = 1'b0;
      ext = 32'h2800_0078;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("pause_state", so1, 32'h0000_0078);
         check("pause_sv", 32'(sv1), 32'd0);
      end
      en = 1'b1;
      cyc(1);
      check("resume_sv_low", 32'(sv1), 32'd0);
      cyc(1);
      check("resume_sv", 32'(sv1), 32'd1);
      check("resume_n3_old", 32'(so1[31:24]), 32'd100);
      cyc(4);
      check("pause_s2_n3_new", 32'(so1[31:24]), 32'd90);
      check("pause_s2_n0", 32'(so1[7:0]), 32'd180);

      // mid-sweep reset with refractory counters active
      rst_pulse();
      ext = 32'h0000_32D2;
      cyc(4);
      check("mrst_pre_spk", 32'(spikes1), 32'd1);
      check("mrst_pre_n1", 32'(so1[15:8]), 32'd50);
      cyc(1);
      rst = 1'b1;
      #1;
      check("mrst_spikes", 32'(spikes1), 32'd0);
      check("mrst_state", so1, 32'd0);
      check("mrst_sv", 32'(sv1), 32'd0);
      #1;
      rst = 1'b0;
      cyc(4);
      check("mrst_post_spk", 32'(spikes1), 32'd1);
      check("mrst_post_n1", 32'(so1[15:8]), 32'd50);
      check("mrst_post_sv", 32'(sv1), 32'd1);

      en = 1'b0;
      cyc(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
